// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - pipeline request/response and memory bus bundle for unified_mem_arbiter
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              pipe_stall;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, pipe_stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, pipe_stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port fixed-latency memory shared by IF and MEM stages, MEM first
module unified_mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 startin,
    unified_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic              owner_mem_q, owner_mem_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic mem_req;
    logic stall;

    assign mem_req = bus.mem_rd_req | bus.mem_wr_req;
    assign stall   = (bus.if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        we_d        = we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cnt_d       = cnt_q;
        if_ready_d  = if_ready_q;
        mem_ready_d = mem_ready_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        // Pipeline advances: results belong to the instruction that just moved on.
        if (!stall) begin
            if_ready_d  = 1'b0;
            mem_ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (mem_req && !mem_ready_q) begin
                    owner_mem_d = 1'b1;
                    we_d        = bus.mem_wr_req;
                    ram_addr_d  = bus.mem_addr;
                    ram_wdata_d = bus.mem_wdata;
                    state_d     = ISSUE;
                end else if (bus.if_req && !if_ready_q) begin
                    owner_mem_d = 1'b0;
                    we_d        = 1'b0;
                    ram_addr_d  = bus.if_addr;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    mem_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (owner_mem_q) begin
                        mem_rdata_d = bus.ram_rdata;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus.ram_rdata;
                        if_ready_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (startin) begin
            state_q     <= IDLE;
            owner_mem_q <= 1'b0;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cnt_q       <= 4'd0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cnt_q       <= cnt_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_en     = (state_q == ISSUE);
    assign bus.ram_we     = (state_q == ISSUE) & we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.pipe_stall = stall;
endmodule
